// File: rtl/divider_arbiter.sv
// Four-way round-robin front end that shares one pipelined divider between requesters.
// Latency: a grant in cycle N produces rsp_valid in cycle N+1+LATENCY; one grant per cycle.
// Backpressure: none; req is held until gnt, and responses cannot be stalled.
// Option: define DIV_BY_ZERO_GUARD_EN to flag zero denominators (rsp_err, all-ones quotient, remainder = numerator).
module divider_arbiter #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   numer_i,
  input  logic [4*WIDTH-1:0]   denom_i,
  output logic [3:0]           gnt,
  output logic [WIDTH-1:0]     div_numer,
  output logic [WIDTH-1:0]     div_denom,
  output logic                 div_clken,
  input  logic [WIDTH-1:0]     div_quotient,
  input  logic [WIDTH-1:0]     div_remain,
  output logic [3:0]           rsp_valid,
  output logic [WIDTH-1:0]     rsp_quotient,
  output logic [WIDTH-1:0]     rsp_remain,
  output logic                 rsp_err,
  output logic                 busy
);

  // Stage 0 lines up with the cycle the operands sit in div_numer/div_denom;
  // stage LATENCY lines up with the divider result for that operation.
  localparam int DEPTH = LATENCY + 1;

  logic [1:0]              ptr;
  logic                    gnt_any;
  logic [1:0]              win;
  logic [WIDTH-1:0]        win_numer;
  logic [WIDTH-1:0]        win_denom;
  logic [DEPTH-1:0]        stg_vld;
  logic [DEPTH-1:0][1:0]   stg_tag;

  // Round-robin search ptr, ptr+1, ... (2-bit wrap); nothing is granted while in reset.
  always_comb begin
    gnt_any = 1'b0;
    win     = ptr;
    for (int i = 0; i < 4; i++) begin
      if (reset && !gnt_any && req[ptr + 2'(i)]) begin
        gnt_any = 1'b1;
        win     = ptr + 2'(i);
      end
    end
  end

  assign gnt       = gnt_any ? (4'b0001 << win) : 4'b0000;
  assign win_numer = numer_i[32'(win)*WIDTH +: WIDTH];
  assign win_denom = denom_i[32'(win)*WIDTH +: WIDTH];
  assign div_clken = gnt_any | (|stg_vld);
  assign busy      = |stg_vld;

  // Capture the winner's operands and advance the pointer past the winner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= 2'd0;
      div_numer <= '0;
      div_denom <= '0;
    end else if (gnt_any) begin
      ptr       <= win + 2'd1;
      div_numer <= win_numer;
      div_denom <= win_denom;
    end
  end

  // Tag pipeline: follows each operation through the divider, moving only when the divider does.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_vld <= '0;
      stg_tag <= '0;
    end else if (div_clken) begin
      stg_vld <= {stg_vld[DEPTH-2:0], gnt_any};
      stg_tag <= {stg_tag[DEPTH-2:0], win};
    end
  end

`ifdef DIV_BY_ZERO_GUARD_EN
  logic [DEPTH-1:0]              stg_err;
  logic [DEPTH-1:0][WIDTH-1:0]   stg_num;

  // Zero-denominator flag and numerator ride alongside the tag so the response can be synthesised locally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_err <= '0;
      stg_num <= '0;
    end else if (div_clken) begin
      stg_err <= {stg_err[DEPTH-2:0], (win_denom == '0)};
      stg_num <= {stg_num[DEPTH-2:0], win_numer};
    end
  end
`endif

  // Response steering: pulse the owner's bit and zero the data bus when nothing is returning.
  always_comb begin
    rsp_valid    = 4'b0000;
    rsp_quotient = '0;
    rsp_remain   = '0;
    rsp_err      = 1'b0;
    if (stg_vld[LATENCY]) begin
      rsp_valid[stg_tag[LATENCY]] = 1'b1;
`ifdef DIV_BY_ZERO_GUARD_EN
      if (stg_err[LATENCY]) begin
        rsp_quotient = '1;
        rsp_remain   = stg_num[LATENCY];
        rsp_err      = 1'b1;
      end else begin
        rsp_quotient = div_quotient;
        rsp_remain   = div_remain;
      end
`else
      rsp_quotient = div_quotient;
      rsp_remain   = div_remain;
`endif
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: directed scenarios plus random traffic against a queue-based scoreboard.
// A behavioural divider (LATENCY clock-enabled stages) stands in for the shared divider.
`timescale 1ns/1ps
module tb_divider_arbiter;
  localparam int WIDTH = 32;
  localparam int LAT   = 4;
  localparam logic [WIDTH-1:0] DIV_GARBAGE = 32'h0BAD_0BAD;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [3:0]           req;
  logic [4*WIDTH-1:0]   numer_i;
  logic [4*WIDTH-1:0]   denom_i;
  logic [3:0]           gnt;
  logic [WIDTH-1:0]     div_numer, div_denom;
  logic                 div_clken;
  logic [WIDTH-1:0]     div_quotient, div_remain;
  logic [3:0]           rsp_valid;
  logic [WIDTH-1:0]     rsp_quotient, rsp_remain;
  logic                 rsp_err;
  logic                 busy;

  divider_arbiter #(.WIDTH(WIDTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .numer_i(numer_i), .denom_i(denom_i),
    .gnt(gnt), .div_numer(div_numer), .div_denom(div_denom), .div_clken(div_clken),
    .div_quotient(div_quotient), .div_remain(div_remain), .rsp_valid(rsp_valid),
    .rsp_quotient(rsp_quotient), .rsp_remain(rsp_remain), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural divider: LAT stages, advancing only on div_clken; zero divisor yields garbage.
  logic [WIDTH-1:0] dq [LAT];
  logic [WIDTH-1:0] dr [LAT];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) begin dq[i] <= '0; dr[i] <= '0; end
    end else if (div_clken) begin
      dq[0] <= (div_denom == 0) ? DIV_GARBAGE : div_numer / div_denom;
      dr[0] <= (div_denom == 0) ? DIV_GARBAGE : div_numer % div_denom;
      for (int i = 1; i < LAT; i++) begin dq[i] <= dq[i-1]; dr[i] <= dr[i-1]; end
    end
  end
  assign div_quotient = dq[LAT-1];
  assign div_remain   = dr[LAT-1];

  typedef struct {
    int               gcyc;
    int               due;
    logic [1:0]       tag;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             err;
  } exp_t;

  exp_t             exp_q[$];
  int               tests = 0;
  int               fails = 0;
  int               cyc = 0;
  int               mptr;
  logic [3:0]       preq;
  logic [WIDTH-1:0] pn [4];
  logic [WIDTH-1:0] pd [4];
  logic [WIDTH-1:0] last_n, last_d;
  logic [3:0]       seen_gnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  // One cycle: drive pending requests, check the grant against the reference, book the expected response.
  task automatic step();
    int   w;
    exp_t e;
    req = preq;
    for (int k = 0; k < 4; k++) begin
      numer_i[k*WIDTH +: WIDTH] = pn[k];
      denom_i[k*WIDTH +: WIDTH] = pd[k];
    end
    @(negedge clk);
    w = -1;
    for (int i = 0; i < 4; i++)
      if (w < 0 && preq[(mptr + i) % 4]) w = (mptr + i) % 4;
    seen_gnt = gnt;
    chk("gnt", gnt, (w < 0) ? 64'd0 : (64'd1 << w));
    chk("div_operands", {div_numer, div_denom}, {last_n, last_d});
    if (w >= 0) begin
      e.gcyc = cyc;
      e.due  = cyc + 1 + LAT;
      e.tag  = 2'(w);
      if (pd[w] == 0) begin
`ifdef DIV_BY_ZERO_GUARD_EN
        e.q = '1; e.r = pn[w]; e.err = 1'b1;
`else
        e.q = DIV_GARBAGE; e.r = DIV_GARBAGE; e.err = 1'b0;
`endif
      end else begin
        e.q = pn[w] / pd[w]; e.r = pn[w] % pd[w]; e.err = 1'b0;
      end
      exp_q.push_back(e);
      last_n  = pn[w];
      last_d  = pd[w];
      mptr    = (w + 1) % 4;
      preq[w] = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard whenever a response is presented, and checks busy/clken every cycle.
  exp_t me;
  bit   bexp;
  always @(negedge clk) begin
    if (reset) begin
      bexp = 1'b0;
      foreach (exp_q[i]) if (exp_q[i].gcyc < cyc) bexp = 1'b1;
      chk("busy", busy, bexp);
      chk("div_clken", div_clken, bexp || (req != 0));
      if (rsp_valid != 0) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rsp", rsp_valid, 0);
        end else begin
          me = exp_q.pop_front();
          chk("rsp_cycle", cyc, me.due);
          chk("rsp_valid", rsp_valid, 64'd1 << me.tag);
          chk("rsp_quotient", rsp_quotient, me.q);
          chk("rsp_remain", rsp_remain, me.r);
          chk("rsp_err", rsp_err, me.err);
        end
      end else begin
        chk("idle_rsp_data", {rsp_quotient, rsp_remain}, 0);
        chk("idle_rsp_err", rsp_err, 0);
        if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
          chk("missing_rsp", rsp_valid, 64'd1 << exp_q[0].tag);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    preq = 4'b0000;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    preq = 4'b0000; mptr = 0; last_n = '0; last_d = '0;
    numer_i = '0; denom_i = '0;
    for (int k = 0; k < 4; k++) begin pn[k] = '0; pd[k] = '0; end
    req = 4'hF;
    #12;
    chk("reset_gnt", gnt, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", {rsp_quotient, rsp_remain}, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_busy", busy, 0);
    chk("reset_clken", div_clken, 0);
    chk("reset_div_ops", {div_numer, div_denom}, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // All four requesting from the first cycle after reset.
    pn[0] = 1000; pd[0] = 3; pn[1] = 77; pd[1] = 5;
    pn[2] = 100;  pd[2] = 7; pn[3] = 9;  pd[3] = 2;
    preq = 4'hF;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("all4_gnt", seen_gnt, 64'd1 << i);
    end
    idle(8);

    // Single operation from requester 2: 100 / 7.
    pn[2] = 100; pd[2] = 7; preq = 4'b0100;
    step();
    chk("single_gnt", seen_gnt, 4'b0100);
    idle(7);

    // Fairness: requester 0 served, then 0 and 3 both keep requesting.
    pn[0] = 11; pd[0] = 4; pn[3] = 500; pd[3] = 9;
    preq = 4'b0001;
    step();
    chk("fair_first", seen_gnt, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      preq = 4'b1001;
      step();
      chk("fair_alt", seen_gnt, (i % 2 == 0) ? 4'b1000 : 4'b0001);
    end
    idle(7);

    // Zero denominator.
    pn[1] = 55; pd[1] = 0; preq = 4'b0010;
    step();
    idle(7);

    // Long idle stretch: nothing moves.
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("idle_clken", div_clken, 0);
      chk("idle_busy", busy, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
    end

    // Random traffic, including zero/small/large divisors and dropped requests.
    for (int s = 0; s < 300; s++) begin
      for (int k = 0; k < 4; k++) begin
        if (!preq[k] && $urandom_range(0, 2) == 0) begin
          preq[k] = 1'b1;
          pn[k] = $urandom;
          case ($urandom_range(0, 3))
            0:       pd[k] = '0;
            1:       pd[k] = $urandom_range(1, 15);
            2:       pd[k] = $urandom;
            default: pd[k] = $urandom_range(1, 1000);
          endcase
        end else if (preq[k] && $urandom_range(0, 15) == 0) begin
          preq[k] = 1'b0;
        end
      end
      step();
    end
    idle(8);

    // Reset with three operations in flight.
    pn[0] = 21; pd[0] = 2; pn[1] = 22; pd[1] = 3; pn[2] = 23; pd[2] = 4;
    preq = 4'b0111;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    #1;
    chk("flush_busy", busy, 0);
    chk("flush_rsp_valid", rsp_valid, 0);
    chk("flush_clken", div_clken, 0);
    chk("flush_gnt", gnt, 0);
    exp_q.delete();
    mptr = 0; last_n = '0; last_d = '0; preq = 4'b0000;
    @(posedge clk); #1;
    reset = 1'b1;
    pn[1] = 40; pd[1] = 6; pn[3] = 41; pd[3] = 5;
    preq = 4'b1010;
    step();
    chk("post_reset_gnt", seen_gnt, 4'b0010);
    idle(10);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/divider_arbiter.md
DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter LATENCY, default 4: fixed pipeline latency of the shared divider, in clock-enabled cycles; legal range 1..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  4  per-requester request, held until granted.
REQ-006 numer_i  input  4*WIDTH  packed numerators; requester k occupies bits [k*WIDTH +: WIDTH].
REQ-007 denom_i  input  4*WIDTH  packed denominators, same packing.
REQ-008 gnt  output  4  one-hot grant, combinational from req and the priority pointer.
REQ-009 div_numer, div_denom  output  WIDTH each  registered operands to the shared divider.
REQ-010 div_clken  output  1  divider clock enable.
REQ-011 div_quotient, div_remain  input  WIDTH each  divider results.
REQ-012 rsp_valid  output  4  one-cycle response pulse to the owning requester.
REQ-013 rsp_quotient, rsp_remain  output  WIDTH each  response data, valid while any rsp_valid bit is high.
REQ-014 rsp_err  output  1  divide-by-zero flag, qualified by rsp_valid.
REQ-015 busy  output  1  high while any operation is in flight.

Function
REQ-016 Arbitration: round-robin; search order starts at pointer ptr (2 bits) and proceeds ptr, ptr+1, ... mod 4; the first requester with req high wins.
REQ-017 At most one gnt bit is high per cycle; gnt is all-zero when req is zero.
REQ-018 On a grant in cycle N, the winner's operands are registered into div_numer/div_denom at the end of cycle N, and ptr becomes winner+1 mod 4.
REQ-019 When there is no grant, ptr and div_numer/div_denom hold their values.
REQ-020 Tag pipeline: a LATENCY+1 deep shift register of {valid, 2-bit tag, err, saved numerator} tracks each issued operation and shifts only when div_clken is high.
REQ-021 div_clken is high in any cycle where a grant occurs or any tag stage is valid; otherwise it is low.
REQ-022 Latency: the response for a grant in cycle N appears in cycle N+1+LATENCY.
REQ-023 In that response cycle, rsp_valid[tag] = 1 and rsp_quotient/rsp_remain = div_quotient/div_remain.
REQ-024 Throughput: one grant per cycle; back-to-back grants produce back-to-back responses in grant order.
REQ-025 A requester may re-assert req in its own response cycle or earlier; up to LATENCY+1 operations may be outstanding across any requesters.
REQ-026 A req deasserted before grant is dropped silently; a gnt that is never taken is not possible because gnt is combinational on current req.
REQ-027 busy = OR of all valid bits in the tag pipeline.
REQ-028 When rsp_valid is zero, rsp_quotient, rsp_remain and rsp_err are 0.

Reset
REQ-029 While reset is low: gnt = 0, rsp_valid = 0, rsp_quotient = 0, rsp_remain = 0, rsp_err = 0, busy = 0, div_clken = 0, div_numer = 0, div_denom = 0, ptr = 0, and all tag stages are invalid.
REQ-030 Reset asserted mid-operation flushes all in-flight operations; no rsp_valid is produced for them after reset releases.
REQ-031 The first cycle after reset release is eligible for a grant.

Configuration
REQ-032 Macro DIV_BY_ZERO_GUARD_EN.
REQ-033 Defined: when the granted denominator is 0, the err bit is set in the tag stage; at the response, rsp_quotient = all ones, rsp_remain = the saved numerator, and rsp_err = 1; the divider output is ignored for that operation and latency is unchanged.
REQ-034 Not defined: the err bit and saved numerator are not implemented, rsp_err is constant 0, and divider results pass through unmodified.

Verification
REQ-035 Single operation: requester 2, numer 100, denom 7, LATENCY 4 -> gnt = 0100 in cycle N; rsp_valid = 0100 in cycle N+5 with quotient 14, remainder 2.
REQ-036 All four requesters high from reset -> grants 0001, 0010, 0100, 1000 on consecutive cycles; four consecutive responses in the same order.
REQ-037 Fairness: req = 1001 held continuously after requester 0 has been granted -> grants alternate 1000, 0001, 1000, ...
REQ-038 With the guard enabled: numer 55, denom 0 -> rsp_err = 1, quotient 0xFFFFFFFF, remainder 55 at N+5; with the guard disabled, rsp_err = 0.
REQ-039 Reset pulsed low with 3 operations in flight -> busy = 0 immediately, no rsp_valid afterwards, and the next grant follows ptr = 0 order.
REQ-040 Idle for 10 cycles -> div_clken = 0, busy = 0, and rsp_valid = 0 throughout.
